// File: rtl/rvdff_pipe.sv
// rvdff_pipe: elastic pipeline register of DEPTH stages, WIDTH bits each.
// Every stage carries its own valid bit. An empty stage always takes its
// predecessor, so bubbles collapse toward the output even while the
// output is stalled.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid and ready are both high. in_ready is combinational from
// out_ready and flush, through a DEPTH-long OR chain. It never depends on
// in_valid or in_data. out_valid and out_data come straight from the last
// stage's flops. They are held while out_valid & ~out_ready, and they
// drop without a transfer only on flush or rst.
module rvdff_pipe #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_src_v;
  logic [WIDTH-1:0] w_src_d [DEPTH];
  logic             w_chain;
  logic [CW-1:0]    w_count;

  // Readiness chain: a stage can load if it is empty or its successor can load.
  always_comb begin
    w_rdy          = '0;
    w_chain        = ~r_v[DEPTH-1] | out_ready;
    w_rdy[DEPTH-1] = w_chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_chain  = ~r_v[i] | w_chain;
      w_rdy[i] = w_chain;
    end
  end

  // Source of each stage: the upstream port for stage 0, else the previous stage.
  always_comb begin
    w_src_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_src_d[i] = '0;
    end
    w_src_v[0] = in_valid;
    w_src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_v[i] = r_v[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

  // Occupancy: popcount of the stage valid bits.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CW'(r_v[i]);
    end
  end

  // Stage update. Reset clears valid and data. Flush clears valid only.
  // Data loads only on a valid source, so bubbles do not toggle the data flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_src_v[i];
          if (w_src_v[i]) begin
            r_d[i] <= w_src_d[i];
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = w_count;

endmodule

// File: tb/tb_rvdff_pipe.sv
// Bench for rvdff_pipe: one DEPTH=3 instance and one DEPTH=1 instance.
// Directed vector tables cover reset, streaming, stall/collapse,
// full pass-through, flush and the DEPTH=1 corner. A randomized phase
// follows. Throughout, a slot-occupancy model with a data queue checks
// every cycle.
module tb_rvdff_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with DEPTH=3 (index 0 in the model)
  logic        iv3, fl3, ordy3, ir3, ov3;
  logic [13:0] id3, od3;
  logic [1:0]  cnt3;
  // DUT with DEPTH=1 (index 1 in the model)
  logic        iv1, fl1, ordy1, ir1, ov1;
  logic [13:0] id1, od1;
  logic [0:0]  cnt1;

  rvdff_pipe #(.WIDTH(14), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_data(id3),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(ordy3),
    .count(cnt3)
  );

  rvdff_pipe #(.WIDTH(14), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(ordy1),
    .count(cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // The model tracks which slots hold a beat, plus the beats in arrival order.
  // Within a cycle the output slot is emptied first if it is consumed.
  // Then each beat advances one slot if the slot ahead is free.
  // A new beat enters slot 0 if slot 0 is then free.
  logic [13:0] exp_q3[$];
  logic [13:0] exp_q1[$];
  int          m_v[2][3];
  logic        prev_hold[2];
  logic [13:0] prev_od[2];

  task automatic model_step(input int k);
    int d;
    int tv[3];
    int ecnt;
    logic iv, ordy, fl, ov, ir, pop;
    logic [13:0] id, od, front;
    int cnt;
    string nm;
    d = (k == 0) ? 3 : 1;
    nm = (k == 0) ? "d3" : "d1";
    if (k == 0) begin
      iv = iv3; id = id3; ordy = ordy3; fl = fl3; ov = ov3; od = od3; ir = ir3; cnt = int'(cnt3);
    end else begin
      iv = iv1; id = id1; ordy = ordy1; fl = fl1; ov = ov1; od = od1; ir = ir1; cnt = int'(cnt1);
    end
    ecnt = 0;
    for (int i = 0; i < 3; i++) begin
      tv[i] = m_v[k][i];
      if (i < d) ecnt += tv[i];
    end
    check({nm, "_mdl_out_valid"}, 32'(ov), 32'(tv[d-1]));
    check({nm, "_mdl_count"}, 32'(cnt), 32'(ecnt));
    if (prev_hold[k]) begin
      check({nm, "_hold_valid"}, 32'(ov), 32'd1);
      check({nm, "_hold_data"}, 32'(od), 32'(prev_od[k]));
    end
    pop = (tv[d-1] == 1) && ordy;
    if (pop) tv[d-1] = 0;
    for (int i = d - 2; i >= 0; i--) begin
      if (tv[i] == 1 && tv[i+1] == 0) begin
        tv[i+1] = 1;
        tv[i]   = 0;
      end
    end
    check({nm, "_mdl_in_ready"}, 32'(ir), 32'((tv[0] == 0) && !fl));
    if (pop) begin
      if (k == 0) begin
        if (exp_q3.size() == 0) check({nm, "_q_empty"}, 32'd1, 32'd0);
        else begin front = exp_q3.pop_front(); check({nm, "_sb_data"}, 32'(od), 32'(front)); end
      end else begin
        if (exp_q1.size() == 0) check({nm, "_q_empty"}, 32'd1, 32'd0);
        else begin front = exp_q1.pop_front(); check({nm, "_sb_data"}, 32'(od), 32'(front)); end
      end
    end
    prev_hold[k] = ov && !ordy && !fl && !rst;
    prev_od[k]   = od;
    if (rst || fl) begin
      for (int i = 0; i < 3; i++) tv[i] = 0;
      if (k == 0) exp_q3.delete(); else exp_q1.delete();
    end else if (iv && tv[0] == 0) begin
      tv[0] = 1;
      if (k == 0) exp_q3.push_back(id); else exp_q1.push_back(id);
    end
    for (int i = 0; i < 3; i++) m_v[k][i] = tv[i];
  endtask

  // Monitor runs 2 time units after each falling edge, after the driver and the table checks.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    int          k;
    logic        iv;
    logic [13:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [13:0] e_od;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int k, input logic iv, input logic [13:0] id, input logic ordy,
                         input logic fl, input logic e_ir, input logic e_ov,
                         input logic [13:0] e_od, input int e_cnt);
    vec_t v;
    v.k = k; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    iv3 = 1'b0; id3 = '0; ordy3 = 1'b1; fl3 = 1'b0;
    iv1 = 1'b0; id1 = '0; ordy1 = 1'b1; fl1 = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string nm;
    logic ir, ov;
    logic [13:0] od;
    int cnt;
    @(negedge clk);
    drive_idle();
    if (v.k == 0) begin
      iv3 = v.iv; id3 = v.id; ordy3 = v.ordy; fl3 = v.fl;
    end else begin
      iv1 = v.iv; id1 = v.id; ordy1 = v.ordy; fl1 = v.fl;
    end
    #1;
    if (v.k == 0) begin ir = ir3; ov = ov3; od = od3; cnt = int'(cnt3); end
    else begin ir = ir1; ov = ov1; od = od1; cnt = int'(cnt1); end
    nm = $sformatf("vec%0d", idx);
    check({nm, "_in_ready"}, 32'(ir), 32'(v.e_ir));
    check({nm, "_out_valid"}, 32'(ov), 32'(v.e_ov));
    check({nm, "_count"}, 32'(cnt), 32'(v.e_cnt));
    if (v.e_ov) check({nm, "_out_data"}, 32'(od), 32'(v.e_od));
  endtask

  task automatic do_reset_test();
    rst = 1'b1;
    drive_idle();
    iv3 = 1'b1; id3 = 14'h3FFF;
    iv1 = 1'b1; id1 = 14'h3FFF;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst1_out_valid", 32'(ov3), 32'd0);
    check("rst1_out_data", 32'(od3), 32'd0);
    check("rst1_count", 32'(cnt3), 32'd0);
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    check("rst2_out_valid", 32'(ov3), 32'd0);
    check("rst2_out_data", 32'(od3), 32'd0);
    check("rst2_count", 32'(cnt3), 32'd0);
    check("rst2_d1_out_valid", 32'(ov1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    check("rel_in_ready", 32'(ir3), 32'd1);
    check("rel_out_valid", 32'(ov3), 32'd0);
    check("rel_out_data", 32'(od3), 32'd0);
    check("rel_count", 32'(cnt3), 32'd0);
    check("rel_d1_in_ready", 32'(ir1), 32'd1);
  endtask

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1;
    drive_idle();

    // Streaming, DEPTH=3, out_ready=1: beats 1..8 come out in cycles 3..10.
    for (int c = 0; c < 12; c++) begin
      int cs;
      cs = (c < 3) ? c : (c <= 8) ? 3 : 11 - c;
      add_vec(0, c < 8, (c < 8) ? 14'(c + 1) : 14'h0, 1'b1, 1'b0,
              1'b1, (c >= 3) && (c <= 10), 14'(c - 2), cs);
    end
    // Stall and collapse, DEPTH=3.
    add_vec(0, 1, 14'h0AAA, 0, 0, 1, 0, 14'h0,    0);
    add_vec(0, 0, 14'h0,    0, 0, 1, 0, 14'h0,    1);
    add_vec(0, 1, 14'h0BBB, 0, 0, 1, 0, 14'h0,    1);
    add_vec(0, 0, 14'h0,    0, 0, 1, 1, 14'h0AAA, 2);
    add_vec(0, 1, 14'h0CCC, 0, 0, 1, 1, 14'h0AAA, 2);
    add_vec(0, 0, 14'h0,    0, 0, 0, 1, 14'h0AAA, 3);
    add_vec(0, 0, 14'h0,    1, 0, 1, 1, 14'h0AAA, 3);
    add_vec(0, 0, 14'h0,    1, 0, 1, 1, 14'h0BBB, 2);
    add_vec(0, 0, 14'h0,    1, 0, 1, 1, 14'h0CCC, 1);
    add_vec(0, 0, 14'h0,    1, 0, 1, 0, 14'h0,    0);
    // Full pass-through, DEPTH=3.
    add_vec(0, 1, 14'h101, 0, 0, 1, 0, 14'h0,   0);
    add_vec(0, 1, 14'h102, 0, 0, 1, 0, 14'h0,   1);
    add_vec(0, 1, 14'h103, 0, 0, 1, 0, 14'h0,   2);
    add_vec(0, 1, 14'h104, 1, 0, 1, 1, 14'h101, 3);
    add_vec(0, 1, 14'h105, 1, 0, 1, 1, 14'h102, 3);
    add_vec(0, 1, 14'h106, 1, 0, 1, 1, 14'h103, 3);
    add_vec(0, 1, 14'h107, 1, 0, 1, 1, 14'h104, 3);
    add_vec(0, 0, 14'h0,   1, 0, 1, 1, 14'h105, 3);
    add_vec(0, 0, 14'h0,   1, 0, 1, 1, 14'h106, 2);
    add_vec(0, 0, 14'h0,   1, 0, 1, 1, 14'h107, 1);
    add_vec(0, 0, 14'h0,   1, 0, 1, 0, 14'h0,   0);
    // Flush with two beats held and a new beat offered.
    add_vec(0, 1, 14'h111, 0, 0, 1, 0, 14'h0,   0);
    add_vec(0, 1, 14'h222, 0, 0, 1, 0, 14'h0,   1);
    add_vec(0, 0, 14'h0,   0, 0, 1, 0, 14'h0,   2);
    add_vec(0, 1, 14'h333, 0, 1, 0, 1, 14'h111, 2);
    add_vec(0, 0, 14'h0,   1, 0, 1, 0, 14'h0,   0);
    add_vec(0, 0, 14'h0,   1, 0, 1, 0, 14'h0,   0);
    add_vec(0, 0, 14'h0,   1, 0, 1, 0, 14'h0,   0);
    // DEPTH=1 with out_ready alternating 1/0.
    add_vec(1, 1, 14'h10, 1, 0, 1, 0, 14'h0,  0);
    add_vec(1, 1, 14'h11, 0, 0, 0, 1, 14'h10, 1);
    add_vec(1, 1, 14'h11, 1, 0, 1, 1, 14'h10, 1);
    add_vec(1, 1, 14'h12, 0, 0, 0, 1, 14'h11, 1);
    add_vec(1, 1, 14'h12, 1, 0, 1, 1, 14'h11, 1);
    add_vec(1, 1, 14'h13, 0, 0, 0, 1, 14'h12, 1);
    add_vec(1, 1, 14'h13, 1, 0, 1, 1, 14'h12, 1);
    add_vec(1, 0, 14'h0,  0, 0, 0, 1, 14'h13, 1);
    add_vec(1, 0, 14'h0,  1, 0, 1, 1, 14'h13, 1);
    add_vec(1, 0, 14'h0,  1, 0, 1, 0, 14'h0,  0);

    do_reset_test();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], i);
    end

    // Randomized phase. The model checks every cycle. Backpressure is heavy
    // in the first half and light in the second half.
    for (int c = 0; c < 2000; c++) begin
      int rmax;
      rmax = (c < 1000) ? 2 : 5;
      @(negedge clk);
      rst   = ($urandom_range(0, 149) == 0);
      iv3   = ($urandom_range(0, 3) != 0);
      id3   = 14'($urandom_range(0, 16383));
      ordy3 = ($urandom_range(0, rmax) >= 2);
      fl3   = ($urandom_range(0, 24) == 0);
      iv1   = ($urandom_range(0, 3) != 0);
      id1   = 14'($urandom_range(0, 16383));
      ordy1 = ($urandom_range(0, rmax) >= 2);
      fl1   = ($urandom_range(0, 24) == 0);
    end

    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (5) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
